tick_counter: RTL and testbench

//  Parametrised timebase + LED/value counter. A prescaler divides clk into one-cycle ticks
//  (default 1 s at 125 MHz); each tick steps a WIDTH-bit counter in up, down, ping-pong or hold mode.

---
 rtl/tick_counter.sv | 158 +++++++++++++++
 tb/tb_tick_counter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_counter.sv
// tick_counter: prescaled timebase that steps a small up/down/ping-pong counter.
// Drives board LEDs and provides the one-cycle tick shared by later labs.
module tick_counter #(
   parameter int unsigned CLKS_PER_TICK = 125_000_000,
   parameter int unsigned WIDTH         = 4,
   parameter bit          SATURATE      = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] value,
   output logic             tick,
   output logic             tc
);

   localparam int unsigned PW =
      (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
   localparam logic [PW-1:0] LAST = PW'(CLKS_PER_TICK - 1);
   localparam logic [PW-1:0] P_ONE = PW'(1);

   localparam logic [WIDTH-1:0] MAX  = '1;
   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   typedef enum logic [1:0] {
      M_UP   = 2'b00,
      M_DOWN = 2'b01,
      M_PING = 2'b10,
      M_HOLD = 2'b11
   } mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   logic [PW-1:0]    presc_q;
   logic             step;
   logic [WIDTH-1:0] nxt_value;
   logic             nxt_tc;
   dir_e             pp_dir;
   dir_e             dir_q;
   dir_e             dir_d;

   // a step happens on the last prescaler count while enabled
   assign step = ce && (presc_q == LAST);

   // next count, terminal-count flag and ping-pong direction for a step
   always_comb begin
      nxt_value = value;
      nxt_tc    = 1'b0;
      pp_dir    = dir_q;
      unique case (mode_e'(mode))
         M_UP: begin
            if (value == MAX) begin
               nxt_value = SATURATE ? MAX : ZERO;
               nxt_tc    = 1'b1;
            end else begin
               nxt_value = value + ONE;
            end
         end
         M_DOWN: begin
            if (value == ZERO) begin
               nxt_value = SATURATE ? ZERO : MAX;
               nxt_tc    = 1'b1;
            end else begin
               nxt_value = value - ONE;
            end
         end
         M_PING: begin
            if (dir_q == DIR_UP) begin
               if (value == MAX) begin
                  // entered at the top while heading up: turn quietly
                  nxt_value = value - ONE;
                  pp_dir    = DIR_DOWN;
               end else begin
                  nxt_value = value + ONE;
                  if (value == MAX - ONE) begin
                     pp_dir = DIR_DOWN;
                     nxt_tc = 1'b1;
                  end
               end
            end else begin
               if (value == ZERO) begin
                  // entered at the bottom while heading down: turn quietly
                  nxt_value = ONE;
                  pp_dir    = DIR_UP;
               end else begin
                  nxt_value = value - ONE;
                  if (value == ONE) begin
                     pp_dir = DIR_UP;
                     nxt_tc = 1'b1;
                  end
               end
            end
         end
         M_HOLD: begin
            nxt_value = value;
         end
      endcase
   end

   // direction next-state: load forces up, a step takes the ping-pong result
   always_comb begin
      dir_d = dir_q;
      if (load) begin
         dir_d = DIR_UP;
      end else if (step) begin
         dir_d = pp_dir;
      end
   end

   // direction state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dir_q <= DIR_UP;
      end else begin
         dir_q <= dir_d;
      end
   end

   // prescaler: free-runs while enabled, cleared by load or a step
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q <= '0;
      end else if (load || step) begin
         presc_q <= '0;
      end else if (ce) begin
         presc_q <= presc_q + P_ONE;
      end
   end

   // counter value: load wins over a coincident step
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= '0;
      end else if (load) begin
         value <= load_value;
      end else if (step) begin
         value <= nxt_value;
      end
   end

   // one-cycle tick and terminal-count pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick <= 1'b0;
         tc   <= 1'b0;
      end else begin
         tick <= step && !load;
         tc   <= step && !load && nxt_tc;
      end
   end

endmodule

// File: tb/tb_tick_counter.sv
// tb_tick_counter: directed checks of tick_counter with a 4-cycle tick.
// A second instance built with SATURATE=1 shares the same stimulus.
module tb_tick_counter;

   logic       clk;
   logic       rst;
   logic       ce;
   logic [1:0] mode;
   logic       load;
   logic [3:0] load_value;
   logic [3:0] value;
   logic       tick;
   logic       tc;
   logic [3:0] value_s;
   logic       tick_s;
   logic       tc_s;

   int n_cmp = 0;
   int n_err = 0;

   tick_counter #(.CLKS_PER_TICK(4), .WIDTH(4), .SATURATE(1'b0)) dut (
      .clk(clk), .rst(rst), .ce(ce), .mode(mode), .load(load),
      .load_value(load_value), .value(value), .tick(tick), .tc(tc)
   );

   tick_counter #(.CLKS_PER_TICK(4), .WIDTH(4), .SATURATE(1'b1)) dut_s (
      .clk(clk), .rst(rst), .ce(ce), .mode(mode), .load(load),
      .load_value(load_value), .value(value_s), .tick(tick_s), .tc(tc_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      ce = 1'b0;
      load = 1'b0;
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ce = 1'b0;
      mode = 2'b00;
      load = 1'b0;
      load_value = 4'd0;
      cyc(2);
      n_cmp++;
      if ({value, tick, tc} !== 6'b0000_0_0) begin
         n_err++;
         $display("FAIL reset: got v=%0d t=%b c=%b want 0 0 0",
                  value, tick, tc);
      end
      rst = 1'b0;
   endtask

   task automatic test_up();
      logic [3:0] ev;
      do_reset();
      mode = 2'b00;
      ce = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         cyc(3);
         n_cmp++;
         if (tick !== 1'b0) begin
            n_err++;
            $display("FAIL up_gap k=%0d: tick=%b want 0", k, tick);
         end
         cyc(1);
         ev = 4'(k);
         n_cmp++;
         if (tick !== 1'b1 || value !== ev || tc !== (k == 16)) begin
            n_err++;
            $display("FAIL up k=%0d: got t=%b v=%0d c=%b want 1 %0d %b",
                     k, tick, value, tc, ev, (k == 16));
         end
      end
   endtask

   task automatic test_down();
      do_reset();
      mode = 2'b01;
      ce = 1'b1;
      cyc(4);
      n_cmp++;
      if (tick !== 1'b1 || value !== 4'd15 || tc !== 1'b1) begin
         n_err++;
         $display("FAIL down_wrap: got t=%b v=%0d c=%b want 1 15 1",
                  tick, value, tc);
      end
      n_cmp++;
      if (tick_s !== 1'b1 || value_s !== 4'd0 || tc_s !== 1'b1) begin
         n_err++;
         $display("FAIL down_sat: got t=%b v=%0d c=%b want 1 0 1",
                  tick_s, value_s, tc_s);
      end
      cyc(1);
      n_cmp++;
      if (tc !== 1'b0 || tc_s !== 1'b0 || tick !== 1'b0) begin
         n_err++;
         $display("FAIL down_pulse: got c=%b cs=%b t=%b want 0 0 0",
                  tc, tc_s, tick);
      end
      cyc(3);
      n_cmp++;
      if (value !== 4'd14 || tc !== 1'b0) begin
         n_err++;
         $display("FAIL down_2: got v=%0d c=%b want 14 0", value, tc);
      end
      n_cmp++;
      if (value_s !== 4'd0 || tc_s !== 1'b1) begin
         n_err++;
         $display("FAIL down_sat2: got v=%0d c=%b want 0 1",
                  value_s, tc_s);
      end
   endtask

   task automatic test_up_sat();
      do_reset();
      mode = 2'b00;
      load_value = 4'd14;
      load = 1'b1;
      cyc(1);
      load = 1'b0;
      ce = 1'b1;
      cyc(4);
      n_cmp++;
      if (value !== 4'd15 || tc !== 1'b0 || value_s !== 4'd15) begin
         n_err++;
         $display("FAIL up_sat1: got v=%0d c=%b vs=%0d want 15 0 15",
                  value, tc, value_s);
      end
      cyc(4);
      n_cmp++;
      if (value !== 4'd0 || tc !== 1'b1) begin
         n_err++;
         $display("FAIL up_wrap: got v=%0d c=%b want 0 1", value, tc);
      end
      n_cmp++;
      if (value_s !== 4'd15 || tc_s !== 1'b1) begin
         n_err++;
         $display("FAIL up_sat2: got v=%0d c=%b want 15 1",
                  value_s, tc_s);
      end
   endtask

   task automatic test_pingpong();
      logic [3:0] ev;
      logic       et;
      do_reset();
      mode = 2'b10;
      ce = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         cyc(4);
         if (k <= 15) ev = 4'(k);
         else if (k <= 30) ev = 4'(30 - k);
         else ev = 4'(k - 30);
         et = (k == 15) || (k == 30);
         n_cmp++;
         if (tick !== 1'b1 || value !== ev || tc !== et) begin
            n_err++;
            $display("FAIL ping k=%0d: got t=%b v=%0d c=%b want 1 %0d %b",
                     k, tick, value, tc, ev, et);
         end
         n_cmp++;
         if (value_s !== ev || tc_s !== et) begin
            n_err++;
            $display("FAIL ping_sat k=%0d: got v=%0d c=%b want %0d %b",
                     k, value_s, tc_s, ev, et);
         end
      end
   endtask

   task automatic test_ce();
      do_reset();
      mode = 2'b00;
      ce = 1'b1;
      cyc(4);
      cyc(2);
      ce = 1'b0;
      for (int i = 0; i < 7; i++) begin
         cyc(1);
         n_cmp++;
         if (value !== 4'd1 || tick !== 1'b0) begin
            n_err++;
            $display("FAIL ce_freeze i=%0d: got v=%0d t=%b want 1 0",
                     i, value, tick);
         end
      end
      ce = 1'b1;
      cyc(1);
      n_cmp++;
      if (tick !== 1'b0 || value !== 4'd1) begin
         n_err++;
         $display("FAIL ce_early: got t=%b v=%0d want 0 1", tick, value);
      end
      cyc(1);
      n_cmp++;
      if (tick !== 1'b1 || value !== 4'd2) begin
         n_err++;
         $display("FAIL ce_resume: got t=%b v=%0d want 1 2", tick, value);
      end
   endtask

   task automatic test_load();
      do_reset();
      mode = 2'b00;
      ce = 1'b1;
      cyc(3);
      load_value = 4'd9;
      load = 1'b1;
      cyc(1);
      load = 1'b0;
      n_cmp++;
      if (value !== 4'd9 || tick !== 1'b0 || tc !== 1'b0) begin
         n_err++;
         $display("FAIL load_step: got v=%0d t=%b c=%b want 9 0 0",
                  value, tick, tc);
      end
      cyc(3);
      n_cmp++;
      if (tick !== 1'b0 || value !== 4'd9) begin
         n_err++;
         $display("FAIL load_gap: got t=%b v=%0d want 0 9", tick, value);
      end
      cyc(1);
      n_cmp++;
      if (tick !== 1'b1 || value !== 4'd10) begin
         n_err++;
         $display("FAIL load_next: got t=%b v=%0d want 1 10", tick, value);
      end
      ce = 1'b0;
      load_value = 4'd15;
      load = 1'b1;
      cyc(1);
      load = 1'b0;
      n_cmp++;
      if (value !== 4'd15) begin
         n_err++;
         $display("FAIL load_noce: got v=%0d want 15", value);
      end
      mode = 2'b10;
      ce = 1'b1;
      cyc(4);
      n_cmp++;
      if (tick !== 1'b1 || value !== 4'd14 || tc !== 1'b0) begin
         n_err++;
         $display("FAIL ping_top: got t=%b v=%0d c=%b want 1 14 0",
                  tick, value, tc);
      end
   endtask

   task automatic test_hold();
      do_reset();
      load_value = 4'd7;
      load = 1'b1;
      cyc(1);
      load = 1'b0;
      mode = 2'b11;
      ce = 1'b1;
      cyc(4);
      n_cmp++;
      if (tick !== 1'b1 || value !== 4'd7 || tc !== 1'b0) begin
         n_err++;
         $display("FAIL hold: got t=%b v=%0d c=%b want 1 7 0",
                  tick, value, tc);
      end
   endtask

   task automatic test_async_rst();
      do_reset();
      mode = 2'b00;
      ce = 1'b1;
      cyc(6);
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (value !== 4'd0 || value_s !== 4'd0) begin
         n_err++;
         $display("FAIL async_rst: got v=%0d vs=%0d want 0 0",
                  value, value_s);
      end
      cyc(1);
      rst = 1'b0;
      cyc(3);
      n_cmp++;
      if (tick !== 1'b0 || value !== 4'd0) begin
         n_err++;
         $display("FAIL rst_gap: got t=%b v=%0d want 0 0", tick, value);
      end
      cyc(1);
      n_cmp++;
      if (tick !== 1'b1 || value !== 4'd1) begin
         n_err++;
         $display("FAIL rst_restart: got t=%b v=%0d want 1 1",
                  tick, value);
      end
   endtask

   initial begin
      test_reset();
      test_up();
      test_down();
      test_up_sat();
      test_pingpong();
      test_ce();
      test_load();
      test_hold();
      test_async_rst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
